dmem_responder: RTL and testbench



---
 rtl/dmem_responder_pkg.sv | 33 +++
 rtl/dmem_responder_if.sv | 25 ++
 rtl/dmem_responder_byte_array.sv | 28 ++
 rtl/dmem_responder.sv | 102 ++++++++++
 tb/tb_dmem_responder.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the multi-cycle data-memory responder.
// Holds the FSM state enum, transfer-size constants and size decoding.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } dmem_state_t;

   localparam logic [3:0] SZ_B = 4'd1;
   localparam logic [3:0] SZ_H = 4'd2;
   localparam logic [3:0] SZ_W = 4'd4;
   localparam logic [3:0] SZ_D = 4'd8;

   function automatic logic size_legal(input logic [3:0] size);
      return (size == SZ_B) || (size == SZ_H) || (size == SZ_W) || (size == SZ_D);
   endfunction

   // One bit per byte lane touched by a transfer of the given size.
   function automatic logic [7:0] lane_mask(input logic [3:0] size);
      logic [7:0] m;
      case (size)
         SZ_B:    m = 8'h01;
         SZ_H:    m = 8'h03;
         SZ_W:    m = 8'h0F;
         SZ_D:    m = 8'hFF;
         default: m = 8'h00;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the CPU memory stage and the data-memory responder.
// Both channels use valid/ready: a transfer happens on a rising edge where valid and
// ready are both 1; the sender holds valid and its payload stable until that edge.
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [63:0] req_addr;
   logic [3:0]  req_size;
   logic [63:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_write, req_addr, req_size, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_size, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/dmem_responder_byte_array.sv
// Byte-wide storage with eight lane write enables and a 64-bit window read.
// Lane k addresses base+k; writes are synchronous, reads combinational, no reset.
module dmem_byte_array #(
   parameter int ADDR_BITS = 10
) (
   input  logic                 clk,
   input  logic [ADDR_BITS-1:0] addr_i,
   input  logic [7:0]           wen_i,
   input  logic [63:0]          wdata_i,
   output logic [63:0]          rdata_o
);

   logic [7:0] mem_q [0:(1<<ADDR_BITS)-1];

   always_ff @(posedge clk) begin
      for (int k = 0; k < 8; k++) begin
         if (wen_i[k]) mem_q[addr_i + ADDR_BITS'(k)] <= wdata_i[8*k +: 8];
      end
   end

   always_comb begin
      rdata_o = '0;
      for (int k = 0; k < 8; k++) begin
         rdata_o[8*k +: 8] = mem_q[addr_i + ADDR_BITS'(k)];
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one load/store, waits LATENCY cycles,
// performs the checked, size-masked access and holds the response until taken.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_BITS = 10,
   parameter int LATENCY   = 2
) (
   input  logic            clk,
   input  logic            reset_n,
   dmem_responder_if.slave bus,
   output dmem_state_t     dbg_state_o
);

   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   dmem_state_t state_q;
   logic [3:0]  cnt_q;
   logic        wr_q;
   logic [63:0] addr_q;
   logic [3:0]  size_q;
   logic [63:0] wdata_q;
   logic [63:0] rdata_q;
   logic        err_q;

   logic        req_err;
   logic        commit;
   logic [7:0]  lanes;
   logic [7:0]  wen;
   logic [63:0] lane_bits;
   logic [63:0] mem_rdata;

   // Alignment only matters for legal sizes; size-1 is then a low-bit mask (8 wraps to 7).
   always_comb begin
      req_err = !size_legal(size_q)
                || (|(addr_q[2:0] & (size_q[2:0] - 3'd1)))
                || (|addr_q[63:ADDR_BITS]);
      lanes   = req_err ? 8'h00 : lane_mask(size_q);
      commit  = (state_q == BUSY) && (cnt_q == 4'd0);
      wen     = (commit && wr_q) ? lanes : 8'h00;
      lane_bits = '0;
      for (int k = 0; k < 8; k++) lane_bits[8*k +: 8] = {8{lanes[k]}};
   end

   dmem_byte_array #(.ADDR_BITS(ADDR_BITS)) u_mem (
      .clk     (clk),
      .addr_i  (addr_q[ADDR_BITS-1:0]),
      .wen_i   (wen),
      .wdata_i (wdata_q),
      .rdata_o (mem_rdata)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         size_q  <= 4'd0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.req_valid) begin
                  wr_q    <= bus.req_write;
                  addr_q  <= bus.req_addr;
                  size_q  <= bus.req_size;
                  wdata_q <= bus.req_wdata;
                  cnt_q   <= CNT_INIT;
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               if (commit) begin
                  rdata_q <= wr_q ? 64'd0 : (mem_rdata & lane_bits);
                  err_q   <= req_err;
                  state_q <= RESP;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            RESP: begin
               if (bus.resp_ready) begin
                  rdata_q <= '0;
                  err_q   <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.req_ready  = (state_q == IDLE);
   assign bus.resp_valid = (state_q == RESP);
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;
   assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (latency 2, 1, 15) checked against a
// byte-level reference memory built from the load/store and error rules.
module tb_dmem_responder;
   import dmem_pkg::*;

   localparam int AB        = 10;
   localparam int MEM_BYTES = 1 << AB;
   localparam int NI        = 3;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic        req_valid_a  [NI];
   logic        req_ready_a  [NI];
   logic        req_write_a  [NI];
   logic [63:0] req_addr_a   [NI];
   logic [3:0]  req_size_a   [NI];
   logic [63:0] req_wdata_a  [NI];
   logic        resp_valid_a [NI];
   logic        resp_ready_a [NI];
   logic [63:0] resp_rdata_a [NI];
   logic        resp_err_a   [NI];
   dmem_state_t state_a      [NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int L = (g == 0) ? 2 : (g == 1) ? 1 : 15;
      dmem_responder_if bus ();
      assign bus.req_valid  = req_valid_a[g];
      assign bus.req_write  = req_write_a[g];
      assign bus.req_addr   = req_addr_a[g];
      assign bus.req_size   = req_size_a[g];
      assign bus.req_wdata  = req_wdata_a[g];
      assign bus.resp_ready = resp_ready_a[g];
      assign req_ready_a[g]  = bus.req_ready;
      assign resp_valid_a[g] = bus.resp_valid;
      assign resp_rdata_a[g] = bus.resp_rdata;
      assign resp_err_a[g]   = bus.resp_err;
      dmem_responder #(.ADDR_BITS(AB), .LATENCY(L)) u_dut (
         .clk         (clk),
         .reset_n     (reset_n),
         .bus         (bus.slave),
         .dbg_state_o (state_a[g])
      );
   end

   function automatic int lat_of(input int sel);
      return (sel == 0) ? 2 : (sel == 1) ? 1 : 15;
   endfunction

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_pass   = 0;
   logic [63:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
      else n_pass++;
   endtask

   // Reference memory: key = instance*4096 + byte address.
   logic [7:0] ref_mem [int];

   function automatic void model(input int sel, input bit wr, input logic [63:0] addr,
                                 input logic [3:0] size, input logic [63:0] wdata,
                                 output logic [63:0] rdata, output bit err);
      int key;
      err = !(size == 4'd1 || size == 4'd2 || size == 4'd4 || size == 4'd8);
      if (addr >= 64'(MEM_BYTES)) err = 1'b1;
      if (!err && (addr % 64'(size)) != 64'd0) err = 1'b1;
      rdata = '0;
      if (!err) begin
         for (int k = 0; k < int'(size); k++) begin
            key = sel * 4096 + int'(addr[AB-1:0]) + k;
            if (wr) ref_mem[key] = wdata[8*k +: 8];
            else rdata[8*k +: 8] = ref_mem.exists(key) ? ref_mem[key] : 8'hxx;
         end
      end
   endfunction

   // ---------------- driver ----------------
   task automatic do_txn(input int sel, input bit wr, input logic [63:0] addr,
                         input logic [3:0] size, input logic [63:0] wdata, input int hold,
                         output logic [63:0] rdata, output bit err);
      logic [63:0] exp_d;
      bit          exp_e;
      int          lat;
      int          waited;
      rdata  = '0;
      err    = 1'b0;
      waited = 0;
      @(negedge clk);
      while (!req_ready_a[sel] && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!req_ready_a[sel]) begin
         check("req_ready_wait", 64'(req_ready_a[sel]), 64'd1);
         return;
      end
      req_write_a[sel]  = wr;
      req_addr_a[sel]   = addr;
      req_size_a[sel]   = size;
      req_wdata_a[sel]  = wdata;
      req_valid_a[sel]  = 1'b1;
      resp_ready_a[sel] = (hold == 0);
      @(posedge clk);
      model(sel, wr, addr, size, wdata, exp_d, exp_e);
      exp_q.push_back(exp_d);
      @(negedge clk);
      req_valid_a[sel] = 1'b0;
      lat = 0;
      while (!resp_valid_a[sel] && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("accept_to_done", 64'(lat + 1), 64'(lat_of(sel) + 1));
      rdata = resp_rdata_a[sel];
      err   = resp_err_a[sel];
      check("rdata", rdata, exp_q.pop_front());
      check("err", 64'(err), 64'(exp_e));
      if (hold > 0) begin
         repeat (hold) begin
            @(negedge clk);
            check("hold_valid", 64'(resp_valid_a[sel]), 64'd1);
            check("hold_rdata", resp_rdata_a[sel], rdata);
         end
         resp_ready_a[sel] = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      check("resp_done", 64'(resp_valid_a[sel]), 64'd0);
      check("ready_again", 64'(req_ready_a[sel]), 64'd1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [63:0] rd, held, exp_d;
      bit          er, exp_e;
      logic [3:0]  sz;
      logic [63:0] ad;
      logic [3:0]  sizes [11];
      int          waited;
      sizes = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd1, 4'd2, 4'd4, 4'd8, 4'd3, 4'd0, 4'd5};

      for (int i = 0; i < NI; i++) begin
         req_valid_a[i] = 1'b0; req_write_a[i] = 1'b0; req_addr_a[i] = '0;
         req_size_a[i] = '0; req_wdata_a[i] = '0; resp_ready_a[i] = 1'b1;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         check("rst_req_ready", 64'(req_ready_a[i]), 64'd1);
         check("rst_resp_valid", 64'(resp_valid_a[i]), 64'd0);
         check("rst_rdata", resp_rdata_a[i], 64'd0);
         check("rst_err", 64'(resp_err_a[i]), 64'd0);
      end
      reset_n = 1'b1;

      // Directed loads/stores on the latency-2 instance.
      do_txn(0, 1, 64'h10, 4'd8, 64'h1122334455667788, 0, rd, er);
      do_txn(0, 0, 64'h10, 4'd8, 64'd0, 0, rd, er);
      check("tp_ld8", rd, 64'h1122334455667788);
      do_txn(0, 1, 64'h13, 4'd1, 64'hAB, 0, rd, er);
      do_txn(0, 0, 64'h10, 4'd4, 64'd0, 0, rd, er);
      check("tp_ld4", rd, 64'h00000000AB667788);
      do_txn(0, 0, 64'h16, 4'd2, 64'd0, 0, rd, er);
      check("tp_ld2", rd, 64'h0000000000001122);
      do_txn(0, 0, 64'h12, 4'd4, 64'd0, 0, rd, er);
      check("tp_misalign_err", 64'(er), 64'd1);
      do_txn(0, 1, 64'h10, 4'd3, 64'hFFFFFFFFFFFFFFFF, 0, rd, er);
      check("tp_size3_err", 64'(er), 64'd1);
      do_txn(0, 0, 64'h10, 4'd8, 64'd0, 0, rd, er);
      check("tp_unchanged", rd, 64'h11223344AB667788);
      do_txn(0, 0, 64'h400, 4'd8, 64'd0, 0, rd, er);
      check("tp_range_err", 64'(er), 64'd1);

      // Back-pressure with a second request pending.
      @(negedge clk);
      req_write_a[0] = 1'b0; req_addr_a[0] = 64'h10; req_size_a[0] = 4'd8;
      req_valid_a[0] = 1'b1; resp_ready_a[0] = 1'b0;
      @(posedge clk);
      model(0, 0, 64'h10, 4'd8, 64'd0, exp_d, exp_e);
      @(negedge clk);
      req_addr_a[0] = 64'h16; req_size_a[0] = 4'd2;
      waited = 0;
      while (!resp_valid_a[0] && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      held = resp_rdata_a[0];
      check("bp_rdata", held, exp_d);
      repeat (5) begin
         @(negedge clk);
         check("bp_valid", 64'(resp_valid_a[0]), 64'd1);
         check("bp_stable", resp_rdata_a[0], held);
         check("bp_no_accept", 64'(req_ready_a[0]), 64'd0);
      end
      resp_ready_a[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp_released", 64'(req_ready_a[0]), 64'd1);
      @(posedge clk);
      model(0, 0, 64'h16, 4'd2, 64'd0, exp_d, exp_e);
      @(negedge clk);
      check("bp_next_accepted", 64'(req_ready_a[0]), 64'd0);
      req_valid_a[0] = 1'b0;
      waited = 0;
      while (!resp_valid_a[0] && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      check("bp_next_rdata", resp_rdata_a[0], exp_d);
      @(posedge clk);

      // Reset while a store is still in flight.
      do_txn(0, 1, 64'h20, 4'd8, 64'd0, 0, rd, er);
      @(negedge clk);
      req_write_a[0] = 1'b1; req_addr_a[0] = 64'h20; req_size_a[0] = 4'd8;
      req_wdata_a[0] = 64'hDEADBEEFCAFEF00D; req_valid_a[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid_a[0] = 1'b0;
      check("rst_mid_busy", 64'(state_a[0]), 64'(BUSY));
      #2 reset_n = 1'b0;
      #1;
      check("rst_mid_ready", 64'(req_ready_a[0]), 64'd1);
      check("rst_mid_valid", 64'(resp_valid_a[0]), 64'd0);
      check("rst_mid_rdata", resp_rdata_a[0], 64'd0);
      check("rst_mid_err", 64'(resp_err_a[0]), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      do_txn(0, 0, 64'h20, 4'd8, 64'd0, 0, rd, er);
      check("rst_store_dropped", rd, 64'd0);

      // Fill memory, then random traffic with random back-pressure.
      for (int a = 0; a < MEM_BYTES; a += 8)
         do_txn(0, 1, 64'(a), 4'd8, {$urandom, $urandom}, 0, rd, er);
      for (int n = 0; n < 250; n++) begin
         sz = sizes[$urandom_range(0, 10)];
         ad = 64'($urandom_range(0, MEM_BYTES - 1));
         if ($urandom_range(0, 3) != 0 && sz != 4'd0) ad = ad & ~(64'(sz) - 64'd1);
         if ($urandom_range(0, 15) == 0) ad[40] = 1'b1;
         do_txn(0, 1'($urandom_range(0, 1)), ad, sz, {$urandom, $urandom},
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, rd, er);
      end

      // Latency 1 and 15 instances.
      for (int s = 1; s < NI; s++) begin
         held = {$urandom, $urandom};
         do_txn(s, 1, 64'h40, 4'd8, held, 0, rd, er);
         do_txn(s, 0, 64'h40, 4'd8, 64'd0, 0, rd, er);
         check("lat_inst_rdata", rd, held);
         do_txn(s, 0, 64'h41, 4'd2, 64'd0, 2, rd, er);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
